// File: rtl/u_byp_src_pipe_pkg.sv
// Shared widths and the bypass control record used by the producer pipe and the IDU consumer.
// Width macros may be overridden on the command line before this file is compiled.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RF_DEPTH_BIT
`define RF_DEPTH_BIT 5
`endif
`ifndef SUPER_SCALAR_NUM
`define SUPER_SCALAR_NUM 2
`endif

package u_byp_src_pipe_pkg;

  localparam int LANE_NUM = `SUPER_SCALAR_NUM;
  localparam int DW       = `DATA_WIDTH;
  localparam int RW       = `RF_DEPTH_BIT;

  // pipe_vld is deliberately the first (most significant) field: stage kill clears the MSB.
  typedef struct packed {
    logic          pipe_vld;
    logic          rd_vld;
    logic [RW-1:0] rd;
    logic          is_load;
  } byp_ctrl_t;

  // WB carries no is_load: load data is already resolved on entry.
  typedef struct packed {
    logic          pipe_vld;
    logic          rd_vld;
    logic [RW-1:0] rd;
  } wb_ctrl_t;

  typedef struct packed {
    byp_ctrl_t     ctrl;
    logic [DW-1:0] data;
  } lsu_stage_t;

  typedef struct packed {
    wb_ctrl_t      ctrl;
    logic [DW-1:0] data;
  } wb_stage_t;

  // x0 is hardwired zero, so it is never advertised for bypass or written.
  function automatic byp_ctrl_t mk_disp_ctrl(input logic          vld,
                                             input logic          rd_vld,
                                             input logic [RW-1:0] rd,
                                             input logic          is_load);
    byp_ctrl_t c;
    c.pipe_vld = vld;
    c.rd_vld   = rd_vld & (rd != '0);
    c.rd       = rd;
    c.is_load  = is_load;
    return c;
  endfunction

endpackage

// File: rtl/u_byp_src_pipe_stage_reg.sv
// Purpose: one lane of one pipe stage; payload MSB must be pipe_vld, which kill clears.
// Latency: one cycle, d -> q on each non-held edge.
// Backpressure: hold freezes q entirely (hold wins over kill); synchronous reset clears all bits.
module u_byp_stage_reg
  import u_byp_src_pipe_pkg::*;
#(
  parameter int W = $bits(byp_ctrl_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         kill,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= {d[W-1] & ~kill, d[W-2:0]};
    end
  end

endmodule

// File: rtl/u_byp_src_pipe.sv
// Purpose: EX/LSU/WB tracker driving the IDU bypass buses and RF write port (BYP_LSU_LOAD_FWD_EN: LSU-stage load forwarding).
// Latency: dispatch at N -> iex bus N+1, lsu bus N+2, rf bus and RF write N+3.
// Backpressure: none beyond pipe_hold, which freezes every stage and ignores dispatch and flush.
module u_byp_src_pipe
  import u_byp_src_pipe_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANE_NUM-1:0]          disp_pipe_vld,
  input  logic [LANE_NUM-1:0][RW-1:0]  disp_rd,
  input  logic [LANE_NUM-1:0]          disp_rd_vld,
  input  logic [LANE_NUM-1:0]          disp_is_load,
  input  logic [LANE_NUM-1:0][DW-1:0]  alu_result,
  input  logic [LANE_NUM-1:0][DW-1:0]  lsu_load_data,
  input  logic                         pipe_hold,
  input  logic                         iex_flush_vld,
  input  logic                         iex_flush_lane,
  output logic [LANE_NUM-1:0][DW-1:0]  iex_idu_byp_data,
  output logic [LANE_NUM-1:0][RW-1:0]  iex_idu_byp_rd,
  output logic [LANE_NUM-1:0]          iex_idu_byp_rd_vld,
  output logic [LANE_NUM-1:0]          iex_idu_byp_pipe_vld,
  output logic [LANE_NUM-1:0]          iex_idu_byp_is_load,
  output logic [LANE_NUM-1:0][DW-1:0]  lsu_idu_byp_data,
  output logic [LANE_NUM-1:0][RW-1:0]  lsu_idu_byp_rd,
  output logic [LANE_NUM-1:0]          lsu_idu_byp_rd_vld,
  output logic [LANE_NUM-1:0]          lsu_idu_byp_pipe_vld,
  output logic [LANE_NUM-1:0]          lsu_idu_byp_is_load,
  output logic [LANE_NUM-1:0][DW-1:0]  rf_idu_byp_data,
  output logic [LANE_NUM-1:0][RW-1:0]  rf_idu_byp_rd,
  output logic [LANE_NUM-1:0]          rf_idu_byp_rd_vld,
  output logic [LANE_NUM-1:0]          rf_idu_byp_pipe_vld,
  output logic [LANE_NUM-1:0]          rf_wr_en,
  output logic [LANE_NUM-1:0][RW-1:0]  rf_wr_idx,
  output logic [LANE_NUM-1:0][DW-1:0]  rf_wr_data
);

  logic flush;

  assign flush = iex_flush_vld & ~pipe_hold;

  for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
    byp_ctrl_t     ex_d;
    byp_ctrl_t     ex_q;
    lsu_stage_t    lsu_d;
    lsu_stage_t    lsu_q;
    wb_stage_t     wb_d;
    wb_stage_t     wb_q;
    logic [DW-1:0] lsu_res;
    logic          lsu_kill;

    // A flushing branch in EX kills everything younger: all of EX next cycle, and
    // the lanes above it as they move into LSU. Lane 0 is never younger than anything.
    if (i == 0) begin : g_oldest
      assign lsu_kill = 1'b0;
    end else begin : g_younger
      assign lsu_kill = flush & ~iex_flush_lane;
    end

    assign ex_d = mk_disp_ctrl(disp_pipe_vld[i], disp_rd_vld[i], disp_rd[i], disp_is_load[i]);

    u_byp_stage_reg #(.W($bits(byp_ctrl_t))) u_ex_reg (
      .clk  (clk),
      .rst  (rst),
      .hold (pipe_hold),
      .kill (flush),
      .d    (ex_d),
      .q    (ex_q)
    );

    assign lsu_d.ctrl = ex_q;
    assign lsu_d.data = alu_result[i];

    u_byp_stage_reg #(.W($bits(lsu_stage_t))) u_lsu_reg (
      .clk  (clk),
      .rst  (rst),
      .hold (pipe_hold),
      .kill (lsu_kill),
      .d    (lsu_d),
      .q    (lsu_q)
    );

    // Load data is only valid during the LSU cycle, so it is folded in here.
    assign lsu_res = lsu_q.ctrl.is_load ? lsu_load_data[i] : lsu_q.data;

    assign wb_d.ctrl.pipe_vld = lsu_q.ctrl.pipe_vld;
    assign wb_d.ctrl.rd_vld   = lsu_q.ctrl.rd_vld;
    assign wb_d.ctrl.rd       = lsu_q.ctrl.rd;
    assign wb_d.data          = lsu_res;

    u_byp_stage_reg #(.W($bits(wb_stage_t))) u_wb_reg (
      .clk  (clk),
      .rst  (rst),
      .hold (pipe_hold),
      .kill (1'b0),
      .d    (wb_d),
      .q    (wb_q)
    );

    assign iex_idu_byp_data[i]     = alu_result[i];
    assign iex_idu_byp_rd[i]       = ex_q.rd;
    assign iex_idu_byp_rd_vld[i]   = ex_q.rd_vld;
    assign iex_idu_byp_pipe_vld[i] = ex_q.pipe_vld;
    assign iex_idu_byp_is_load[i]  = ex_q.is_load;

    assign lsu_idu_byp_rd[i]       = lsu_q.ctrl.rd;
    assign lsu_idu_byp_rd_vld[i]   = lsu_q.ctrl.rd_vld;
    assign lsu_idu_byp_pipe_vld[i] = lsu_q.ctrl.pipe_vld;
`ifdef BYP_LSU_LOAD_FWD_EN
    // Load result is already on lsu_load_data, so IDU may bypass it without stalling.
    assign lsu_idu_byp_is_load[i]  = 1'b0;
    assign lsu_idu_byp_data[i]     = lsu_res;
`else
    assign lsu_idu_byp_is_load[i]  = lsu_q.ctrl.is_load;
    assign lsu_idu_byp_data[i]     = lsu_q.data;
`endif

    assign rf_idu_byp_data[i]      = wb_q.data;
    assign rf_idu_byp_rd[i]        = wb_q.ctrl.rd;
    assign rf_idu_byp_rd_vld[i]    = wb_q.ctrl.rd_vld;
    assign rf_idu_byp_pipe_vld[i]  = wb_q.ctrl.pipe_vld;

    assign rf_wr_en[i]             = wb_q.ctrl.pipe_vld & wb_q.ctrl.rd_vld;
    assign rf_wr_idx[i]            = wb_q.ctrl.rd;
    assign rf_wr_data[i]           = wb_q.data;
  end

endmodule

// File: tb/tb_u_byp_src_pipe.sv
// Directed bench for u_byp_src_pipe: expected bus snapshots and RF writes are queued at
// issue time and consumed by an independent negedge monitor.
module tb_u_byp_src_pipe;
  import u_byp_src_pipe_pkg::*;

`ifdef BYP_LSU_LOAD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [LANE_NUM-1:0]         disp_pipe_vld = '0;
  logic [LANE_NUM-1:0][RW-1:0] disp_rd       = '0;
  logic [LANE_NUM-1:0]         disp_rd_vld   = '0;
  logic [LANE_NUM-1:0]         disp_is_load  = '0;
  logic [LANE_NUM-1:0][DW-1:0] alu_result    = '0;
  logic [LANE_NUM-1:0][DW-1:0] lsu_load_data = '0;
  logic pipe_hold = 1'b0, iex_flush_vld = 1'b0, iex_flush_lane = 1'b0;

  logic [LANE_NUM-1:0][DW-1:0] iex_idu_byp_data, lsu_idu_byp_data, rf_idu_byp_data, rf_wr_data;
  logic [LANE_NUM-1:0][RW-1:0] iex_idu_byp_rd, lsu_idu_byp_rd, rf_idu_byp_rd, rf_wr_idx;
  logic [LANE_NUM-1:0] iex_idu_byp_rd_vld, iex_idu_byp_pipe_vld, iex_idu_byp_is_load;
  logic [LANE_NUM-1:0] lsu_idu_byp_rd_vld, lsu_idu_byp_pipe_vld, lsu_idu_byp_is_load;
  logic [LANE_NUM-1:0] rf_idu_byp_rd_vld, rf_idu_byp_pipe_vld, rf_wr_en;

  u_byp_src_pipe dut (
    .clk(clk), .rst(rst),
    .disp_pipe_vld(disp_pipe_vld), .disp_rd(disp_rd), .disp_rd_vld(disp_rd_vld),
    .disp_is_load(disp_is_load), .alu_result(alu_result), .lsu_load_data(lsu_load_data),
    .pipe_hold(pipe_hold), .iex_flush_vld(iex_flush_vld), .iex_flush_lane(iex_flush_lane),
    .iex_idu_byp_data(iex_idu_byp_data), .iex_idu_byp_rd(iex_idu_byp_rd),
    .iex_idu_byp_rd_vld(iex_idu_byp_rd_vld), .iex_idu_byp_pipe_vld(iex_idu_byp_pipe_vld),
    .iex_idu_byp_is_load(iex_idu_byp_is_load),
    .lsu_idu_byp_data(lsu_idu_byp_data), .lsu_idu_byp_rd(lsu_idu_byp_rd),
    .lsu_idu_byp_rd_vld(lsu_idu_byp_rd_vld), .lsu_idu_byp_pipe_vld(lsu_idu_byp_pipe_vld),
    .lsu_idu_byp_is_load(lsu_idu_byp_is_load),
    .rf_idu_byp_data(rf_idu_byp_data), .rf_idu_byp_rd(rf_idu_byp_rd),
    .rf_idu_byp_rd_vld(rf_idu_byp_rd_vld), .rf_idu_byp_pipe_vld(rf_idu_byp_pipe_vld),
    .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: pipe_vld only; 1: control and data; 2: control only
  typedef struct {
    int cyc; int bus; int lane; int tid; int mode;
    logic pv; logic rv; logic [RW-1:0] rd; logic [DW-1:0] data; logic ld;
  } bus_exp_t;
  typedef struct { int lane; logic [RW-1:0] idx; logic [DW-1:0] data; } wr_exp_t;

  bus_exp_t bus_q[$];
  wr_exp_t  wr_q[$];
  int checks = 0, errors = 0, tid = 0;

  function automatic string bus_name(input int b);
    return (b == 0) ? "iex" : (b == 1) ? "lsu" : "rf";
  endfunction

  task automatic expb(input int at, input int bus, input int lane, input logic pv, input logic rv,
                      input logic [RW-1:0] rd, input logic [DW-1:0] data, input logic ld,
                      input int mode);
    bus_exp_t e;
    e.cyc = at; e.bus = bus; e.lane = lane; e.tid = tid; e.mode = mode;
    e.pv = pv; e.rv = rv; e.rd = rd; e.data = data; e.ld = ld;
    bus_q.push_back(e);
  endtask

  task automatic expw(input int lane, input logic [RW-1:0] idx, input logic [DW-1:0] data);
    wr_exp_t w;
    w.lane = lane; w.idx = idx; w.data = data;
    wr_q.push_back(w);
  endtask

  task automatic check_bus(input bus_exp_t e);
    logic pv, rv, ld;
    logic [RW-1:0] rd;
    logic [DW-1:0] d;
    bit ok;
    case (e.bus)
      0: begin
        pv = iex_idu_byp_pipe_vld[e.lane]; rv = iex_idu_byp_rd_vld[e.lane];
        rd = iex_idu_byp_rd[e.lane]; d = iex_idu_byp_data[e.lane]; ld = iex_idu_byp_is_load[e.lane];
      end
      1: begin
        pv = lsu_idu_byp_pipe_vld[e.lane]; rv = lsu_idu_byp_rd_vld[e.lane];
        rd = lsu_idu_byp_rd[e.lane]; d = lsu_idu_byp_data[e.lane]; ld = lsu_idu_byp_is_load[e.lane];
      end
      default: begin
        pv = rf_idu_byp_pipe_vld[e.lane]; rv = rf_idu_byp_rd_vld[e.lane];
        rd = rf_idu_byp_rd[e.lane]; d = rf_idu_byp_data[e.lane]; ld = 1'b0;
      end
    endcase
    ok = (pv === e.pv);
    if (e.mode != 0) ok = ok && (rv === e.rv) && (rd === e.rd) && (ld === e.ld);
    if (e.mode == 1) ok = ok && (d === e.data);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL t%0d_%s%0d cyc%0d got pv=%b rv=%b rd=%0d ld=%b d=%h want pv=%b rv=%b rd=%0d ld=%b d=%h (mode %0d)",
               e.tid, bus_name(e.bus), e.lane, cyc, pv, rv, rd, ld, d,
               e.pv, e.rv, e.rd, e.ld, e.data, e.mode);
    end
  endtask

  // Monitor: bus snapshots due this cycle, then every asserted RF write against the scoreboard.
  always @(negedge clk) begin
    int hit;
    for (int k = bus_q.size() - 1; k >= 0; k--) begin
      if (bus_q[k].cyc == cyc) begin
        check_bus(bus_q[k]);
        bus_q.delete(k);
      end
    end
    for (int l = 0; l < LANE_NUM; l++) begin
      if (rf_wr_en[l] === 1'b1) begin
        hit = -1;
        for (int k = 0; k < wr_q.size(); k++) if (hit < 0 && wr_q[k].lane == l) hit = k;
        checks++;
        if (hit < 0) begin
          errors++;
          $display("FAIL rf_wr%0d cyc%0d unexpected write idx=%0d data=%h", l, cyc, rf_wr_idx[l], rf_wr_data[l]);
        end else begin
          if (rf_wr_idx[l] !== wr_q[hit].idx || rf_wr_data[l] !== wr_q[hit].data) begin
            errors++;
            $display("FAIL rf_wr%0d cyc%0d got idx=%0d data=%h want idx=%0d data=%h",
                     l, cyc, rf_wr_idx[l], rf_wr_data[l], wr_q[hit].idx, wr_q[hit].data);
          end
          wr_q.delete(hit);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_disp();
    disp_pipe_vld = '0; disp_rd = '0; disp_rd_vld = '0; disp_is_load = '0;
  endtask

  task automatic disp(input int lane, input logic [RW-1:0] rd, input logic rv, input logic ld);
    disp_pipe_vld[lane] = 1'b1; disp_rd[lane] = rd; disp_rd_vld[lane] = rv; disp_is_load[lane] = ld;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog cyc%0d bench did not complete", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int c;
    alu_result[0] = 32'h5A5A_5A5A; alu_result[1] = 32'h1111_1111;
    step(); step();
    rst = 1'b0;
    // reset state: everything zero, iex data follows alu_result
    tid = 0;
    expb(cyc, 0, 0, 0, 0, 0, 32'h5A5A_5A5A, 0, 1);
    expb(cyc, 0, 1, 0, 0, 0, 32'h1111_1111, 0, 1);
    for (int l = 0; l < LANE_NUM; l++) begin
      expb(cyc, 1, l, 0, 0, 0, 0, 0, 1);
      expb(cyc, 2, l, 0, 0, 0, 0, 0, 1);
    end
    step();

    // 1: simple ALU op through all stages
    tid = 1; c = cyc;
    disp(0, 5, 1, 0);
    expb(c+1, 0, 0, 1, 1, 5, 32'hA5, 0, 1);
    expb(c+1, 0, 1, 0, 0, 0, 0, 0, 0);
    expb(c+2, 1, 0, 1, 1, 5, 32'hA5, 0, 1);
    expb(c+3, 2, 0, 1, 1, 5, 32'hA5, 0, 1);
    expw(0, 5, 32'hA5);
    step(); clear_disp(); alu_result = '0; alu_result[0] = 32'hA5;
    step(); alu_result = '0;
    repeat (3) step();

    // 2: rd = x0 on both lanes is never bypassed or written
    tid = 2; c = cyc;
    disp(0, 0, 1, 0); disp(1, 0, 1, 0);
    expb(c+1, 0, 0, 1, 0, 0, 32'h33, 0, 1);
    expb(c+1, 0, 1, 1, 0, 0, 32'h44, 0, 1);
    expb(c+2, 1, 0, 1, 0, 0, 32'h33, 0, 1);
    expb(c+3, 2, 0, 1, 0, 0, 32'h33, 0, 1);
    expb(c+3, 2, 1, 1, 0, 0, 32'h44, 0, 1);
    step(); clear_disp(); alu_result[0] = 32'h33; alu_result[1] = 32'h44;
    step(); alu_result = '0;
    repeat (3) step();

    // 3: lane 1 load, data merged on entry to WB
    tid = 3; c = cyc;
    disp(1, 7, 1, 1);
    expb(c+1, 0, 1, 1, 1, 7, 32'hDEAD, 1, 1);
    expb(c+2, 1, 1, 1, 1, 7, FWD ? 32'h1234 : 32'hDEAD, !FWD, 1);
    expb(c+3, 2, 1, 1, 1, 7, 32'h1234, 0, 1);
    expw(1, 7, 32'h1234);
    step(); clear_disp(); alu_result[1] = 32'hDEAD;
    step(); alu_result = '0; lsu_load_data[1] = 32'h1234;
    step(); lsu_load_data = '0;
    repeat (3) step();

    // 4: flush from lane 0 kills EX lane 1 and the same-cycle dispatch
    tid = 4; c = cyc;
    disp(0, 1, 1, 0); disp(1, 2, 1, 0);
    expb(c+1, 0, 0, 1, 1, 1, 32'h11, 0, 1);
    expb(c+1, 0, 1, 1, 1, 2, 32'h22, 0, 1);
    expb(c+2, 0, 0, 0, 0, 0, 0, 0, 0);
    expb(c+2, 0, 1, 0, 0, 0, 0, 0, 0);
    expb(c+2, 1, 0, 1, 1, 1, 32'h11, 0, 1);
    expb(c+2, 1, 1, 0, 0, 0, 0, 0, 0);
    expb(c+3, 2, 0, 1, 1, 1, 32'h11, 0, 1);
    expb(c+3, 2, 1, 0, 0, 0, 0, 0, 0);
    expb(c+3, 1, 0, 0, 0, 0, 0, 0, 0);
    expb(c+3, 1, 1, 0, 0, 0, 0, 0, 0);
    expw(0, 1, 32'h11);
    step();
    disp(0, 3, 1, 0); disp(1, 4, 1, 0);
    alu_result[0] = 32'h11; alu_result[1] = 32'h22;
    iex_flush_vld = 1'b1; iex_flush_lane = 1'b0;
    step(); clear_disp(); alu_result = '0; iex_flush_vld = 1'b0;
    repeat (4) step();

    // 4b: flush from lane 1 lets both EX lanes advance
    tid = 5; c = cyc;
    disp(0, 8, 1, 0); disp(1, 9, 1, 0);
    expb(c+2, 0, 0, 0, 0, 0, 0, 0, 0);
    expb(c+2, 1, 0, 1, 1, 8, 32'h80, 0, 1);
    expb(c+2, 1, 1, 1, 1, 9, 32'h90, 0, 1);
    expb(c+3, 0, 0, 0, 0, 0, 0, 0, 0);
    expw(0, 8, 32'h80); expw(1, 9, 32'h90);
    step(); clear_disp(); disp(0, 10, 1, 0);
    alu_result[0] = 32'h80; alu_result[1] = 32'h90;
    iex_flush_vld = 1'b1; iex_flush_lane = 1'b1;
    step(); clear_disp(); alu_result = '0; iex_flush_vld = 1'b0; iex_flush_lane = 1'b0;
    repeat (4) step();

    // 5: three-cycle hold mid-stream with a flush that must be ignored
    tid = 6; c = cyc;
    disp(0, 11, 1, 0);
    for (int t = c + 2; t <= c + 5; t++) begin
      expb(t, 0, 1, 1, 1, 12, 32'hB2, 0, 1);
      expb(t, 0, 0, 0, 0, 0, 0, 0, 0);
      expb(t, 1, 0, 1, 1, 11, 32'hB1, 0, 1);
      expb(t, 1, 1, 0, 0, 0, 0, 0, 0);
      expb(t, 2, 0, 0, 0, 0, 0, 0, 0);
    end
    expb(c+6, 2, 0, 1, 1, 11, 32'hB1, 0, 1);
    expb(c+6, 1, 1, 1, 1, 12, 32'hB2, 0, 1);
    expb(c+6, 0, 1, 0, 0, 0, 0, 0, 0);
    expb(c+7, 2, 1, 1, 1, 12, 32'hB2, 0, 1);
    expw(0, 11, 32'hB1); expw(1, 12, 32'hB2);
    step(); clear_disp(); disp(1, 12, 1, 0); alu_result[0] = 32'hB1;
    step(); clear_disp(); alu_result = '0; alu_result[1] = 32'hB2;
    pipe_hold = 1'b1; iex_flush_vld = 1'b1; iex_flush_lane = 1'b0;
    repeat (3) step();
    pipe_hold = 1'b0; iex_flush_vld = 1'b0;
    step(); alu_result = '0;
    repeat (4) step();

    // 6: reset with all stages full; dispatch in the reset cycle is dropped
    tid = 7; c = cyc;
    disp(0, 13, 1, 0); disp(1, 14, 1, 0);
    expb(c+3, 2, 0, 1, 1, 13, 32'hD0, 0, 1);
    expb(c+3, 2, 1, 1, 1, 14, 32'hE0, 0, 1);
    expb(c+3, 1, 0, 1, 1, 15, 32'hD1, 0, 1);
    expb(c+3, 0, 0, 1, 1, 17, 32'hD2, 0, 1);
    expw(0, 13, 32'hD0); expw(1, 14, 32'hE0);
    expb(c+4, 0, 0, 0, 0, 0, 32'hBB, 0, 1);
    expb(c+4, 0, 1, 0, 0, 0, 32'hCC, 0, 1);
    for (int l = 0; l < LANE_NUM; l++) begin
      expb(c+4, 1, l, 0, 0, 0, 0, 0, 1);
      expb(c+4, 2, l, 0, 0, 0, 0, 0, 1);
      expb(c+5, 0, l, 0, 0, 0, 0, 0, 0);
      expb(c+6, 1, l, 0, 0, 0, 0, 0, 0);
    end
    step(); disp(0, 15, 1, 0); disp(1, 16, 1, 0); alu_result[0] = 32'hD0; alu_result[1] = 32'hE0;
    step(); disp(0, 17, 1, 0); disp(1, 18, 1, 0); alu_result[0] = 32'hD1; alu_result[1] = 32'hE1;
    step(); disp(0, 19, 1, 0); disp(1, 20, 1, 0); alu_result[0] = 32'hD2; alu_result[1] = 32'hE2;
    rst = 1'b1;
    step(); rst = 1'b0; clear_disp(); alu_result[0] = 32'hBB; alu_result[1] = 32'hCC;
    repeat (5) step();

    checks++;
    if (bus_q.size() != 0) begin
      errors++;
      $display("FAIL bus_q_drain got %0d pending want 0", bus_q.size());
    end
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL rf_wr_drain got %0d missing writes want 0", wr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
